// File: rtl/scan_sched_if.sv
// scan_sched_if
// Bundles the job-request side and the address-output side of the scan
// scheduler into one interface.
//   req_valid/req_ready       per-requester job handshake (NREQ bits)
//   req_base/x_max/x_stride   per-requester job config, slice i = [i*WIDTH +: WIDTH]
//   abort                     synchronous cancel of the running job
//   addr_valid/addr_ready     address stream handshake
//   addr_out/addr_last        streamed address and end-of-job marker
//   addr_owner                requester index of the running (or last) job
//   busy/done                 job in progress / one-cycle completion pulse
// Modports: master = job issuers plus address consumer, slave = scheduler.
interface scan_sched_if #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 2
);
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_base;
  logic [NREQ*WIDTH-1:0] req_x_max;
  logic [NREQ*WIDTH-1:0] req_x_stride;
  logic                  abort;
  logic                  addr_valid;
  logic                  addr_ready;
  logic [WIDTH-1:0]      addr_out;
  logic                  addr_last;
  logic [ID_W-1:0]       addr_owner;
  logic                  busy;
  logic                  done;

  modport master (
    output req_valid, req_base, req_x_max, req_x_stride, abort, addr_ready,
    input  req_ready, addr_valid, addr_out, addr_last, addr_owner, busy, done
  );

  modport slave (
    input  req_valid, req_base, req_x_max, req_x_stride, abort, addr_ready,
    output req_ready, addr_valid, addr_out, addr_last, addr_owner, busy, done
  );
endinterface

// File: rtl/scan_sched.sv
// scan_sched
// Round-robin scheduler that shares one 1-D strided address scan engine
// among NREQ requesters. One job (base, x_max, x_stride) is granted at a
// time; the engine then emits x_max addresses base, base+stride, ...
// (wrapping silently modulo 2^WIDTH) under consumer backpressure, tags
// them with the owning requester, and pulses done after the last one.
// Ports:
//   clk   clock, all state changes on the rising edge
//   rst   asynchronous active-high reset
//   bus   scan_sched_if slave modport (job requests, abort, address stream,
//         busy/done status)
module scan_sched #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 2,
  localparam int ID_W = $clog2(NREQ)
) (
  input logic        clk,
  input logic        rst,
  scan_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ZERO
  } state_t;

  state_t state;
  state_t next_state;

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  owner_q;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] x_max_q;
  logic [WIDTH-1:0] stride_q;
  logic [WIDTH-1:0] addr_q;
  logic             done_q;

  logic [ID_W-1:0]  winner;
  logic             found;
  logic [ID_W:0]    idx_wide;
  logic [ID_W-1:0]  cand;
  logic [WIDTH-1:0] sel_base;
  logic [WIDTH-1:0] sel_x_max;
  logic [WIDTH-1:0] sel_stride;
  logic [NREQ-1:0]  ready_vec;
  logic             grant;
  logic             finish;
  logic             last;
  logic             advance;

  // Round-robin search starting at rr_ptr. The candidate index is kept one
  // bit wider than ID_W so rr_ptr+k cannot overflow before the modulo
  // fold, which keeps this correct for non-power-of-two NREQ.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    idx_wide = '0;
    cand     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_wide = (ID_W+1)'(rr_ptr) + (ID_W+1)'(k);
      if (idx_wide >= (ID_W+1)'(NREQ)) begin
        idx_wide = idx_wide - (ID_W+1)'(NREQ);
      end
      cand = idx_wide[ID_W-1:0];
      if (!found && bus.req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Config of the current winner; only sampled on the grant handshake.
  assign sel_base   = bus.req_base[int'(winner)*WIDTH +: WIDTH];
  assign sel_x_max  = bus.req_x_max[int'(winner)*WIDTH +: WIDTH];
  assign sel_stride = bus.req_x_stride[int'(winner)*WIDTH +: WIDTH];

  // count never exceeds x_max-1, so x_max = 2^WIDTH-1 needs no extra bit.
  // In RUN x_max_q is non-zero, so the subtraction cannot underflow there.
  assign last = (count == x_max_q - 1'b1);

  // Next-state and handshake decode. req_ready is gated by rst so nothing
  // appears granted while the block is held in reset. abort wins over a
  // simultaneous final handshake, so finish (and later done) stays low.
  always_comb begin
    next_state = state;
    grant      = 1'b0;
    finish     = 1'b0;
    advance    = 1'b0;
    ready_vec  = '0;
    case (state)
      IDLE: begin
        if (found && !rst) begin
          ready_vec[winner] = 1'b1;
          grant             = 1'b1;
          next_state        = (sel_x_max != '0) ? RUN : ZERO;
        end
      end
      RUN: begin
        if (bus.abort) begin
          next_state = IDLE;
        end else if (bus.addr_ready) begin
          if (last) begin
            next_state = IDLE;
            finish     = 1'b1;
          end else begin
            advance = 1'b1;
          end
        end
      end
      ZERO: begin
        next_state = IDLE;
        finish     = !bus.abort;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register plus the latched job. The job config is captured only
  // on grant, so later req_* activity cannot disturb a running scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner_q  <= '0;
      count    <= '0;
      x_max_q  <= '0;
      stride_q <= '0;
      addr_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state  <= next_state;
      done_q <= finish;
      if (grant) begin
        x_max_q  <= sel_x_max;
        stride_q <= sel_stride;
        addr_q   <= sel_base;
        owner_q  <= winner;
        count    <= '0;
        rr_ptr   <= (winner == ID_W'(NREQ - 1)) ? '0 : winner + 1'b1;
      end else if (advance) begin
        count  <= count + 1'b1;
        addr_q <= addr_q + stride_q;
      end
    end
  end

  assign bus.req_ready  = ready_vec;
  assign bus.addr_valid = (state == RUN);
  assign bus.addr_last  = (state == RUN) && last;
  assign bus.addr_out   = addr_q;
  assign bus.addr_owner = owner_q;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_q;

endmodule

// File: tb/tb_scan_sched.sv
// tb_scan_sched
// Self-checking bench for scan_sched. Expected addresses come from
// base + k*stride mod 2^WIDTH and expected grants from a round-robin pick
// over the valid requesters; directed steps are followed by random jobs.
module tb_scan_sched;
  localparam int WIDTH = 16;
  localparam int NREQ  = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  scan_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  scan_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  int job_base   [NREQ];
  int job_xmax   [NREQ];
  int job_stride [NREQ];

  int model_rr;
  int cur_base;
  int cur_xmax;
  int cur_stride;
  int cur_owner;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Put a job on requester i's slice of the request bus and remember it.
  task automatic load(input int i, input int b, input int x, input int s);
    job_base[i]   = b;
    job_xmax[i]   = x;
    job_stride[i] = s;
    bus.req_base[i*WIDTH +: WIDTH]     = WIDTH'(b);
    bus.req_x_max[i*WIDTH +: WIDTH]    = WIDTH'(x);
    bus.req_x_stride[i*WIDTH +: WIDTH] = WIDTH'(s);
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int rr);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (rr + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Called in an IDLE cycle with at least one requester valid: checks the
  // predicted grant, steps over the accepting edge, then optionally drops
  // the winner's valid and scrambles its request bus.
  task automatic grant_check(input bit drop, input bit scramble);
    int w;
    #1;
    w = pick(bus.req_valid, model_rr);
    chk("busy_idle", bus.busy, 0);
    chk("req_ready", bus.req_ready, 32'(1) << w);
    cur_base   = job_base[w];
    cur_xmax   = job_xmax[w];
    cur_stride = job_stride[w];
    cur_owner  = w;
    model_rr   = (w + 1) % NREQ;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    chk("grant_owner", bus.addr_owner, w);
    chk("grant_busy", bus.busy, 1);
    chk("grant_ready_low", bus.req_ready, 0);
    if (drop) bus.req_valid[w] = 1'b0;
    if (scramble) begin
      bus.req_base[w*WIDTH +: WIDTH]     = WIDTH'($urandom);
      bus.req_x_max[w*WIDTH +: WIDTH]    = WIDTH'($urandom);
      bus.req_x_stride[w*WIDTH +: WIDTH] = WIDTH'($urandom);
    end
  endtask

  // Consume the running job. mode 0: always ready, 1: alternate, 2: random.
  // abort_at >= 0 raises abort once that many addresses were accepted.
  // Returns at the first IDLE cycle after the job.
  task automatic stream(input int mode, input int abort_at, input string tag);
    int k;
    int cyc;
    bit fin;
    bit rdy;
    bit ab;
    logic [63:0] e;
    if (cur_xmax == 0) begin
      chk({tag, "_zero_novalid"}, bus.addr_valid, 0);
      chk({tag, "_zero_nodone"}, bus.done, 0);
      @(posedge clk);
      #1;
      chk({tag, "_zero_done"}, bus.done, 1);
      chk({tag, "_zero_idle"}, bus.busy, 0);
      chk({tag, "_zero_novalid2"}, bus.addr_valid, 0);
      return;
    end
    k   = 0;
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < 200) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 2) == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      ab = (abort_at >= 0) && (k == abort_at);
      bus.addr_ready = rdy;
      bus.abort      = ab;
      e = 64'(cur_base) + 64'(k) * 64'(cur_stride);
      chk({tag, "_valid"}, bus.addr_valid, 1);
      chk({tag, "_addr"}, bus.addr_out, 32'(e[WIDTH-1:0]));
      chk({tag, "_last"}, bus.addr_last, (k == cur_xmax - 1) ? 1 : 0);
      chk({tag, "_owner"}, bus.addr_owner, cur_owner);
      chk({tag, "_ready_low"}, bus.req_ready, 0);
      chk({tag, "_nodone"}, bus.done, 0);
      @(posedge clk);
      #1;
      cyc++;
      if (ab) begin
        bus.abort = 1'b0;
        chk({tag, "_abort_novalid"}, bus.addr_valid, 0);
        chk({tag, "_abort_nodone"}, bus.done, 0);
        chk({tag, "_abort_idle"}, bus.busy, 0);
        fin = 1'b1;
      end else if (rdy) begin
        k++;
        if (k == cur_xmax) begin
          chk({tag, "_done"}, bus.done, 1);
          chk({tag, "_end_novalid"}, bus.addr_valid, 0);
          chk({tag, "_end_idle"}, bus.busy, 0);
          fin = 1'b1;
        end
      end
    end
    if (!fin) chk({tag, "_timeout"}, 32'(fin), 1);
    bus.addr_ready = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    chk("idle_nodone", bus.done, 0);
    chk("idle_busy", bus.busy, 0);
  endtask

  initial begin
    int mode;
    int ab_at;
    rst              = 1'b1;
    bus.req_valid    = '0;
    bus.req_base     = '0;
    bus.req_x_max    = '0;
    bus.req_x_stride = '0;
    bus.abort        = 1'b0;
    bus.addr_ready   = 1'b0;
    model_rr         = 0;

    // Reset state
    @(posedge clk);
    #1;
    chk("rst_valid", bus.addr_valid, 0);
    chk("rst_addr", bus.addr_out, 0);
    chk("rst_last", bus.addr_last, 0);
    chk("rst_owner", bus.addr_owner, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ready", bus.req_ready, 0);
    rst = 1'b0;
    idle_cycle();

    // Single job on req0, latched config scrambled afterwards
    $display("[TB] single job");
    load(0, 'h100, 4, 8);
    bus.req_valid[0] = 1'b1;
    grant_check(1, 1);
    stream(0, -1, "single");
    idle_cycle();

    // Same job under alternating backpressure
    $display("[TB] backpressure");
    load(0, 'h100, 4, 8);
    bus.req_valid[0] = 1'b1;
    grant_check(1, 1);
    stream(1, -1, "bp");
    idle_cycle();

    // Both requesters valid continuously; grants must alternate
    $display("[TB] round robin");
    load(0, 'h200, 2, 4);
    load(1, 'h300, 2, 4);
    bus.req_valid = '1;
    for (int j = 0; j < 4; j++) begin
      grant_check(0, 0);
      stream(0, -1, "rr");
    end
    bus.req_valid = '0;
    idle_cycle();

    // Zero-length job, then an address wrap
    $display("[TB] zero and wrap");
    load(1, 'h40, 0, 1);
    bus.req_valid[1] = 1'b1;
    grant_check(1, 0);
    stream(0, -1, "zero");
    load(0, 'hFFF0, 3, 'h10);
    bus.req_valid[0] = 1'b1;
    grant_check(1, 0);
    stream(0, -1, "wrap");
    idle_cycle();

    // Abort after two addresses; req1 then wins
    $display("[TB] abort");
    load(0, 'h500, 5, 2);
    load(1, 'h600, 2, 2);
    bus.req_valid[0] = 1'b1;
    grant_check(1, 0);
    bus.req_valid[1] = 1'b1;
    stream(0, 2, "abort");
    grant_check(1, 0);
    stream(0, -1, "post_abort");
    idle_cycle();

    // Abort coinciding with the final handshake suppresses done
    load(0, 'h700, 3, 1);
    bus.req_valid[0] = 1'b1;
    grant_check(1, 0);
    stream(0, 2, "abort_last");
    idle_cycle();

    // Random jobs, random backpressure, occasional abort (also in IDLE)
    $display("[TB] random jobs");
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] && $urandom_range(0, 1) == 1) begin
          load(i, int'($urandom_range(0, 'hFFFF)), int'($urandom_range(0, 6)),
               int'($urandom_range(0, 'hFFFF)));
          bus.req_valid[i] = 1'b1;
        end
      end
      if (bus.req_valid == '0) begin
        load(0, int'($urandom_range(0, 'hFFFF)), int'($urandom_range(0, 6)),
             int'($urandom_range(0, 'hFFFF)));
        bus.req_valid[0] = 1'b1;
      end
      bus.abort = 1'($urandom_range(0, 1));
      grant_check(1, 1'($urandom_range(0, 1)));
      mode  = int'($urandom_range(0, 2));
      ab_at = -1;
      if (cur_xmax > 0 && $urandom_range(0, 3) == 0) begin
        ab_at = int'($urandom_range(0, cur_xmax - 1));
      end
      stream(mode, ab_at, "rand");
    end
    bus.req_valid = '0;
    idle_cycle();

    // Asynchronous reset in the middle of a job
    $display("[TB] reset mid-run");
    model_rr = 1;
    load(0, 'h800, 6, 3);
    bus.req_valid[0] = 1'b1;
    grant_check(1, 0);
    bus.addr_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus.addr_valid, 0);
    chk("mid_rst_addr", bus.addr_out, 0);
    chk("mid_rst_last", bus.addr_last, 0);
    chk("mid_rst_owner", bus.addr_owner, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    bus.addr_ready = 1'b0;
    load(0, 'h900, 2, 1);
    load(1, 'hA00, 2, 1);
    bus.req_valid = '1;
    #1;
    chk("mid_rst_ready", bus.req_ready, 0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    model_rr = 0;
    grant_check(1, 0);
    chk("post_rst_owner0", bus.addr_owner, 0);
    stream(0, -1, "post_rst");
    bus.req_valid = '0;
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
